mdu_issue: RTL and testbench

Initiator and result owner for the multiply/divide unit (`mdu`) in the multicycle CPU. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO commands from the control FSM and drives the `mdu` request lines, holding operands stable until the result is ready. It then writes the product, or remainder and quotient, into the architectural HI/LO registers. It stalls the CPU while an operation is outstanding and serves MFHI/MFLO reads.

---
 rtl/mdu_pkg.sv | 25 ++
 rtl/hilo_regs.sv | 36 +++
 rtl/mdu_issue.sv | 154 +++++++++++++++
 tb/tb_mdu_issue.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide issue block.
//   - command encodings carried on op
//   - two-state issue FSM enum
//   - LO value written on divide-by-zero
package mdu_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_NOP   = 3'd0;
  localparam logic [OP_W-1:0] OP_MULT  = 3'd1;
  localparam logic [OP_W-1:0] OP_MULTU = 3'd2;
  localparam logic [OP_W-1:0] OP_DIV   = 3'd3;
  localparam logic [OP_W-1:0] OP_DIVU  = 3'd4;
  localparam logic [OP_W-1:0] OP_MTHI  = 3'd5;
  localparam logic [OP_W-1:0] OP_MTLO  = 3'd6;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [XLEN-1:0] DIV0_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/hilo_regs.sv
// Architectural HI/LO register pair with independent write enables.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   hi_we, hi_d   HI write enable / data
//   lo_we, lo_d   LO write enable / data
//   rd_sel        read select, 0=LO 1=HI
//   rd_data       combinational read data
module hilo_regs
  import mdu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            hi_we,
  input  logic [XLEN-1:0] hi_d,
  input  logic            lo_we,
  input  logic [XLEN-1:0] lo_d,
  input  logic            rd_sel,
  output logic [XLEN-1:0] rd_data
);

  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] lo_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (hi_we) hi_q <= hi_d;
      if (lo_we) lo_q <= lo_d;
    end
  end

  assign rd_data = rd_sel ? hi_q : lo_q;

endmodule

// File: rtl/mdu_issue.sv
// Issues MULT/MULTU/DIV/DIVU to the mdu, owns HI/LO, stalls the CPU while a
// request is outstanding and abandons it after TIMEOUT wait cycles.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   op_valid, op, op_a, op_b command from the control FSM (sampled in IDLE)
//   busy                     request outstanding
//   rd_sel, rd_data          MFHI/MFLO read port (rd_data combinational)
//   err                      sticky timeout flag
//   mdu_mul_c, mdu_div_c,
//   mdu_sign, mdu_a, mdu_b   registered request to the mdu
//   mdu_done, mdu_hi, mdu_lo result from the mdu
module mdu_issue
  import mdu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            op_valid,
  input  logic [OP_W-1:0] op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  input  logic            rd_sel,
  output logic [XLEN-1:0] rd_data,
  output logic            err,
  output logic            mdu_mul_c,
  output logic            mdu_div_c,
  output logic            mdu_sign,
  output logic [XLEN-1:0] mdu_a,
  output logic [XLEN-1:0] mdu_b,
  input  logic            mdu_done,
  input  logic [XLEN-1:0] mdu_hi,
  input  logic [XLEN-1:0] mdu_lo
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic             div_by_zero;
  logic             hi_we;
  logic             lo_we;
  logic [XLEN-1:0]  hi_d;
  logic [XLEN-1:0]  lo_d;

  assign div_by_zero = (op_b == '0);

  // HI/LO write selection: immediate writes in IDLE, mdu result in WAIT.
  always_comb begin
    hi_we = 1'b0;
    lo_we = 1'b0;
    hi_d  = mdu_hi;
    lo_d  = mdu_lo;
    if (state == IDLE) begin
      if (op_valid) begin
        case (op)
          OP_MTHI: begin
            hi_we = 1'b1;
            hi_d  = op_a;
          end
          OP_MTLO: begin
            lo_we = 1'b1;
            lo_d  = op_a;
          end
          OP_DIV, OP_DIVU: begin
            // Divide-by-zero is resolved locally without touching the mdu.
            if (div_by_zero) begin
              hi_we = 1'b1;
              lo_we = 1'b1;
              hi_d  = op_a;
              lo_d  = DIV0_LO;
            end
          end
          default: ;
        endcase
      end
    end else if (mdu_done) begin
      hi_we = 1'b1;
      lo_we = 1'b1;
    end
  end

  // Issue FSM with registered request outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
      mdu_mul_c <= 1'b0;
      mdu_div_c <= 1'b0;
      mdu_sign  <= 1'b0;
      mdu_a     <= '0;
      mdu_b     <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (op_valid) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                mdu_a     <= op_a;
                mdu_b     <= op_b;
                mdu_mul_c <= 1'b1;
                mdu_sign  <= (op == OP_MULT);
                busy      <= 1'b1;
                state     <= WAIT;
              end
              OP_DIV, OP_DIVU: begin
                if (!div_by_zero) begin
                  mdu_a     <= op_a;
                  mdu_b     <= op_b;
                  mdu_div_c <= 1'b1;
                  mdu_sign  <= (op == OP_DIV);
                  busy      <= 1'b1;
                  state     <= WAIT;
                end
              end
              default: ;
            endcase
          end
        end
        WAIT: begin
          if (mdu_done || (cnt == CNT_W'(TIMEOUT - 1))) begin
            // A result arriving on the timeout cycle wins over the timeout.
            if (!mdu_done) err <= 1'b1;
            mdu_mul_c <= 1'b0;
            mdu_div_c <= 1'b0;
            mdu_sign  <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  hilo_regs u_hilo (
    .clk     (clk),
    .rst     (rst),
    .hi_we   (hi_we),
    .hi_d    (hi_d),
    .lo_we   (lo_we),
    .lo_d    (lo_d),
    .rd_sel  (rd_sel),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_mdu_issue.sv
// Directed bench for mdu_issue with a stub mdu driven from the vector table.
module tb_mdu_issue;
  import mdu_pkg::*;

  localparam int unsigned TO = 8;

  logic            clk;
  logic            rst;
  logic            op_valid;
  logic [2:0]      op;
  logic [31:0]     op_a;
  logic [31:0]     op_b;
  logic            busy;
  logic            rd_sel;
  logic [31:0]     rd_data;
  logic            err;
  logic            mdu_mul_c;
  logic            mdu_div_c;
  logic            mdu_sign;
  logic [31:0]     mdu_a;
  logic [31:0]     mdu_b;
  logic            mdu_done;
  logic [31:0]     mdu_hi;
  logic [31:0]     mdu_lo;

  int total;
  int bad;

  mdu_issue #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .op_valid  (op_valid),
    .op        (op),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .rd_sel    (rd_sel),
    .rd_data   (rd_data),
    .err       (err),
    .mdu_mul_c (mdu_mul_c),
    .mdu_div_c (mdu_div_c),
    .mdu_sign  (mdu_sign),
    .mdu_a     (mdu_a),
    .mdu_b     (mdu_b),
    .mdu_done  (mdu_done),
    .mdu_hi    (mdu_hi),
    .mdu_lo    (mdu_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // k = cycle in which the stub raises mdu_done; 0 means no mdu request expected
  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          k;
    logic [31:0] mhi;
    logic [31:0] mlo;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        mul;
    logic        div;
    logic        sign;
  } vec_t;

  localparam int NV = 12;
  vec_t vt [NV];

  function automatic vec_t mk(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                              input int k, input logic [31:0] mhi, input logic [31:0] mlo,
                              input logic [31:0] eh, input logic [31:0] el,
                              input logic mul, input logic div, input logic sign);
    vec_t v;
    v.op = o; v.a = a; v.b = b; v.k = k; v.mhi = mhi; v.mlo = mlo;
    v.exp_hi = eh; v.exp_lo = el; v.mul = mul; v.div = div; v.sign = sign;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_hilo(input string tag, input logic [31:0] eh, input logic [31:0] el);
    rd_sel = 1'b1;
    #1;
    chk({tag, " hi"}, rd_data, eh);
    rd_sel = 1'b0;
    #1;
    chk({tag, " lo"}, rd_data, el);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    op_valid = 1'b1; op = v.op; op_a = v.a; op_b = v.b;
    @(negedge clk);
    op_valid = 1'b0;
    for (int c = 1; c <= v.k; c++) begin
      if (c > 1) @(negedge clk);
      chk($sformatf("%s c%0d busy", tag, c), 32'(busy), 32'd1);
      chk($sformatf("%s c%0d mul", tag, c), 32'(mdu_mul_c), 32'(v.mul));
      chk($sformatf("%s c%0d div", tag, c), 32'(mdu_div_c), 32'(v.div));
      chk($sformatf("%s c%0d sign", tag, c), 32'(mdu_sign), 32'(v.sign));
      chk($sformatf("%s c%0d a", tag, c), mdu_a, v.a);
      chk($sformatf("%s c%0d b", tag, c), mdu_b, v.b);
      if (c == v.k) begin
        mdu_done = 1'b1; mdu_hi = v.mhi; mdu_lo = v.mlo;
      end
    end
    if (v.k > 0) begin
      @(negedge clk);
      mdu_done = 1'b0; mdu_hi = 32'hA5A5_A5A5; mdu_lo = 32'h5A5A_5A5A;
    end
    chk({tag, " busy after"}, 32'(busy), 32'd0);
    chk({tag, " mul after"}, 32'(mdu_mul_c), 32'd0);
    chk({tag, " div after"}, 32'(mdu_div_c), 32'd0);
    chk({tag, " err"}, 32'(err), 32'd0);
    chk_hilo(tag, v.exp_hi, v.exp_lo);
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; op_valid = 1'b0; op = OP_NOP; op_a = '0; op_b = '0;
    rd_sel = 1'b0; mdu_done = 1'b0; mdu_hi = 32'hA5A5_A5A5; mdu_lo = 32'h5A5A_5A5A;

    //          op        a             b            k  mhi           mlo           exp_hi        exp_lo        mul div sgn
    vt[0]  = mk(OP_MTHI,  32'h1234_5678, 32'h0,       0, 32'h0,        32'h0,        32'h1234_5678, 32'h0,        0, 0, 0);
    vt[1]  = mk(OP_MTLO,  32'h9ABC_DEF0, 32'h0,       0, 32'h0,        32'h0,        32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 0);
    vt[2]  = mk(OP_NOP,   32'hDEAD_BEEF, 32'h1,       0, 32'h0,        32'h0,        32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 0);
    vt[3]  = mk(3'd7,     32'hBEEF_0000, 32'h0,       0, 32'h0,        32'h0,        32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 0);
    vt[4]  = mk(OP_MULT,  32'hFFFF_FFFE, 32'h3,       4, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1, 0, 1);
    vt[5]  = mk(OP_DIVU,  32'd100,       32'd7,       1, 32'd2,        32'd14,       32'd2,        32'd14,       0, 1, 0);
    vt[6]  = mk(OP_DIV,   32'h8000_0000, 32'h0,       0, 32'h0,        32'h0,        32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
    vt[7]  = mk(OP_DIVU,  32'd5,         32'h0,       0, 32'h0,        32'h0,        32'd5,        32'hFFFF_FFFF, 0, 0, 0);
    vt[8]  = mk(OP_MULTU, 32'h0001_0000, 32'h0001_0000, 2, 32'h1,      32'h0,        32'h1,        32'h0,        1, 0, 0);
    vt[9]  = mk(OP_DIV,   32'hFFFF_FFF9, 32'd2,       3, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 1, 1);
    vt[10] = mk(OP_MTHI,  32'h0,         32'h0,       0, 32'h0,        32'h0,        32'h0,        32'hFFFF_FFFD, 0, 0, 0);
    // done arrives on the last allowed wait cycle: result wins, no err
    vt[11] = mk(OP_MULT,  32'd3,         32'd5,       TO, 32'h0,       32'd15,       32'h0,        32'd15,       1, 0, 1);

    // reset state
    repeat (2) @(negedge clk);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst mul", 32'(mdu_mul_c), 32'd0);
    chk("rst div", 32'(mdu_div_c), 32'd0);
    chk("rst sign", 32'(mdu_sign), 32'd0);
    chk("rst a", mdu_a, 32'd0);
    chk("rst b", mdu_b, 32'd0);
    chk_hilo("rst", 32'd0, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(i, vt[i]);

    // timeout: MULTU never completes; an op_valid during WAIT is ignored
    @(negedge clk);
    op_valid = 1'b1; op = OP_MULTU; op_a = 32'h11; op_b = 32'h22;
    @(negedge clk);
    op_valid = 1'b0;
    for (int c = 1; c <= int'(TO); c++) begin
      if (c > 1) @(negedge clk);
      chk($sformatf("to c%0d busy", c), 32'(busy), 32'd1);
      chk($sformatf("to c%0d mul", c), 32'(mdu_mul_c), 32'd1);
      chk($sformatf("to c%0d sign", c), 32'(mdu_sign), 32'd0);
      chk($sformatf("to c%0d err", c), 32'(err), 32'd0);
      if (c == 3) begin
        op_valid = 1'b1; op = OP_MTHI; op_a = 32'hCAFE_F00D;
      end
      if (c == int'(TO)) op_valid = 1'b0;
    end
    @(negedge clk);
    chk("to busy after", 32'(busy), 32'd0);
    chk("to err", 32'(err), 32'd1);
    chk("to mul after", 32'(mdu_mul_c), 32'd0);
    chk_hilo("to", 32'h0, 32'd15);
    @(negedge clk);
    chk("to err sticky", 32'(err), 32'd1);

    // reset in WAIT cycle 2, then a late mdu_done
    op_valid = 1'b1; op = OP_DIV; op_a = 32'd9; op_b = 32'd3;
    @(negedge clk);
    op_valid = 1'b0;
    chk("rw c1 busy", 32'(busy), 32'd1);
    chk("rw c1 div", 32'(mdu_div_c), 32'd1);
    chk("rw c1 sign", 32'(mdu_sign), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rw busy", 32'(busy), 32'd0);
    chk("rw err", 32'(err), 32'd0);
    chk("rw mul", 32'(mdu_mul_c), 32'd0);
    chk("rw div", 32'(mdu_div_c), 32'd0);
    chk("rw sign", 32'(mdu_sign), 32'd0);
    chk("rw a", mdu_a, 32'd0);
    chk("rw b", mdu_b, 32'd0);
    chk_hilo("rw", 32'd0, 32'd0);
    mdu_done = 1'b1; mdu_hi = 32'h55; mdu_lo = 32'h66;
    @(negedge clk);
    mdu_done = 1'b0;
    chk("late busy", 32'(busy), 32'd0);
    chk_hilo("late", 32'd0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
